audio_dac_out: RTL

- Output stage directly downstream of the 4-channel tone mixer.
- Captures each 16-bit signed mixed sample on its one-cycle valid strobe and converts it to a 1-bit pin stream.
- Two run-time selectable modes: first-order delta-sigma (ΔΣ) or fixed-period PWM.
- Double-buffers samples so a new sample never glitches an in-progress PWM period; flags overruns.

---
 rtl/audio_dac_out_pkg.sv | 13 +
 rtl/audio_dac_out_sample_buffer.sv | 44 ++++
 rtl/audio_dac_out.sv | 83 ++++++++
 3 files changed

// File: rtl/audio_dac_out_pkg.sv
// Shared constants for the audio DAC output stage: default widths, mode
// encodings and the midscale (silence) code in offset binary.
package audio_dac_out_pkg;

  localparam int DAC_SAMPLE_W = 16;
  localparam int DAC_PWM_BITS = 10;

  localparam logic DAC_MODE_DS  = 1'b0;
  localparam logic DAC_MODE_PWM = 1'b1;

  localparam logic [DAC_SAMPLE_W-1:0] DAC_MIDSCALE = 16'h8000;

endpackage

// File: rtl/audio_dac_out_sample_buffer.sv
// Pending/active double buffer: captures offset-binary samples, hands them to
// the active register on load (midscale when muted) and flags overruns.
module dac_sample_buffer
  import audio_dac_out_pkg::*;
#(
  parameter int SAMPLE_W = DAC_SAMPLE_W
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic                mute_in,
  input  logic                load_en,
  output logic [SAMPLE_W-1:0] active_code,
  output logic                pending_flag,
  output logic                overrun
);

  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] pending_buf;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      pending_buf  <= MIDSCALE;
      active_code  <= MIDSCALE;
      pending_flag <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // A simultaneous load consumes the old pending sample, so no overrun.
      overrun <= sample_valid_in && pending_flag && !load_en;
      if (load_en) begin
        active_code <= mute_in ? MIDSCALE : pending_buf;
      end
      if (sample_valid_in) begin
        pending_buf  <= sample_in ^ MIDSCALE;
        pending_flag <= 1'b1;
      end else if (load_en) begin
        pending_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/audio_dac_out.sv
// 1-bit audio output stage: first-order delta-sigma or fixed-period PWM,
// fed from a double-buffered sample register.
module audio_dac_out
  import audio_dac_out_pkg::*;
#(
  parameter int SAMPLE_W = DAC_SAMPLE_W,
  parameter int PWM_BITS = DAC_PWM_BITS
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic                mode_in,
  input  logic                mute_in,
  output logic                dac_out,
  output logic                overrun_out,
  output logic                period_start_out
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic                mode_q;
  logic                mode_chg;
  logic                is_pwm;
  logic                load_en;
  logic                pending_flag;
  logic [SAMPLE_W-1:0] active_code;
  // Only the low SAMPLE_W bits persist; the carry goes straight to dac_out.
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W:0]   acc_sum;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;

  assign is_pwm   = (mode_in == DAC_MODE_PWM);
  assign mode_chg = (mode_q != mode_in);
  assign load_en  = pending_flag && !mode_chg && (!is_pwm || (pwm_cnt == CNT_MAX));
  assign acc_sum  = {1'b0, acc} + {1'b0, active_code};
  assign duty     = active_code[SAMPLE_W-1 -: PWM_BITS];

  dac_sample_buffer #(
    .SAMPLE_W(SAMPLE_W)
  ) u_buffer (
    .clk_in          (clk_in),
    .reset_n_in      (reset_n_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .mute_in         (mute_in),
    .load_en         (load_en),
    .active_code     (active_code),
    .pending_flag    (pending_flag),
    .overrun         (overrun_out)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      mode_q           <= DAC_MODE_DS;
      acc              <= '0;
      pwm_cnt          <= '0;
      dac_out          <= 1'b0;
      period_start_out <= 1'b0;
    end else begin
      mode_q <= mode_in;
      if (mode_chg) begin
        // Silent restart cycle: both datapaths begin from a clean state.
        acc              <= '0;
        pwm_cnt          <= '0;
        dac_out          <= 1'b0;
        period_start_out <= 1'b0;
      end else if (is_pwm) begin
        acc              <= '0;
        pwm_cnt          <= pwm_cnt + PWM_BITS'(1);
        dac_out          <= (pwm_cnt < duty);
        period_start_out <= (pwm_cnt == '0);
      end else begin
        acc              <= acc_sum[SAMPLE_W-1:0];
        pwm_cnt          <= '0;
        dac_out          <= acc_sum[SAMPLE_W];
        period_start_out <= 1'b0;
      end
    end
  end

endmodule
